// File: rtl/tia_pf_pkg.sv
// Shared types and helpers for the playfield serializer: sequencer states and lane geometry.
package tia_pf_pkg;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_LEFT,
        PF_RIGHT
    } pf_state_t;

    localparam int PF_LANE_W = 8;

    function automatic int pf_lanes(input int bits);
        return (bits + PF_LANE_W - 1) / PF_LANE_W;
    endfunction

endpackage

// File: rtl/tia_pf_image.sv
// Playfield image register file, written one byte lane at a time by the CPU-side decode.
module tia_pf_image
    import tia_pf_pkg::*;
#(
    parameter int PF_BITS = 20,
    parameter int LANES   = pf_lanes(PF_BITS),
    parameter int SEL_W   = $clog2(LANES)
) (
    input  logic               clkp,
    input  logic               reset_bar,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic [7:0]         wr_data,
    output logic [PF_BITS-1:0] image
);

    logic [PF_BITS-1:0] image_reg;
    logic [PF_BITS-1:0] image_next;

    // Each image bit belongs to exactly one lane; lanes past LANES-1 never match, so those writes drop.
    for (genvar gi = 0; gi < PF_BITS; gi++) begin : g_bit
        assign image_next[gi] = (wr_en && (wr_sel == SEL_W'(gi / PF_LANE_W)))
                              ? wr_data[gi % PF_LANE_W]
                              : image_reg[gi];
    end

    always_ff @(posedge clkp or negedge reset_bar) begin
        if (!reset_bar) begin
            image_reg <= '0;
        end else begin
            image_reg <= image_next;
        end
    end

    assign image = image_reg;

endmodule

// File: rtl/tia_playfield_serializer.sv
// Playfield serializer: left half forward, right half repeated or mirrored, registered pf/busy.
// Optional score-mode outputs pf_left/pf_right are built when TIA_PF_SCORE_EN is defined.
module tia_playfield_serializer
    import tia_pf_pkg::*;
#(
    parameter  int PF_BITS = 20,
    localparam int LANES   = pf_lanes(PF_BITS),
    localparam int SEL_W   = $clog2(LANES),
    localparam int IDX_W   = $clog2(PF_BITS)
) (
    input  logic             clkp,
    input  logic             reset_bar,
    input  logic             line_start,
    input  logic             tick,
    input  logic             reflect,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [7:0]       wr_data,
`ifdef TIA_PF_SCORE_EN
    output logic             pf_left,
    output logic             pf_right,
`endif
    output logic             pf,
    output logic             busy
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PF_BITS - 1);

    pf_state_t          state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               refl_reg, refl_next;
    logic [PF_BITS-1:0] image;
    logic               pix;

    tia_pf_image #(
        .PF_BITS (PF_BITS),
        .LANES   (LANES),
        .SEL_W   (SEL_W)
    ) u_image (
        .clkp      (clkp),
        .reset_bar (reset_bar),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .image     (image)
    );

    always_ff @(posedge clkp or negedge reset_bar) begin
        if (!reset_bar) begin
            state_reg <= PF_IDLE;
            idx_reg   <= '0;
            refl_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            refl_reg  <= refl_next;
        end
    end

    // line_start dominates: a coincident tick is dropped rather than advancing the restarted line.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        refl_next  = refl_reg;
        if (line_start) begin
            state_next = PF_LEFT;
            idx_next   = '0;
        end else if (tick) begin
            case (state_reg)
                PF_LEFT: begin
                    if (idx_reg == IDX_LAST) begin
                        state_next = PF_RIGHT;
                        refl_next  = reflect;
                        idx_next   = reflect ? IDX_LAST : '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
                PF_RIGHT: begin
                    if (refl_reg ? (idx_reg == '0) : (idx_reg == IDX_LAST)) begin
                        state_next = PF_IDLE;
                    end else if (refl_reg) begin
                        idx_next = idx_reg - IDX_W'(1);
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // Reads the live image so a mid-line write shows up on the bit currently being drawn.
    assign pix = image[idx_reg];

    logic pf_reg, busy_reg;

`ifdef TIA_PF_SCORE_EN
    logic pf_left_reg, pf_right_reg;

    always_ff @(posedge clkp or negedge reset_bar) begin
        if (!reset_bar) begin
            pf_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            pf_left_reg  <= 1'b0;
            pf_right_reg <= 1'b0;
        end else begin
            pf_reg       <= (state_reg != PF_IDLE) & pix;
            busy_reg     <= (state_reg != PF_IDLE);
            pf_left_reg  <= (state_reg == PF_LEFT) & pix;
            pf_right_reg <= (state_reg == PF_RIGHT) & pix;
        end
    end

    assign pf_left  = pf_left_reg;
    assign pf_right = pf_right_reg;
`else
    always_ff @(posedge clkp or negedge reset_bar) begin
        if (!reset_bar) begin
            pf_reg   <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            pf_reg   <= (state_reg != PF_IDLE) & pix;
            busy_reg <= (state_reg != PF_IDLE);
        end
    end
`endif

    assign pf   = pf_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_tia_playfield_serializer.sv
// Bench for tia_playfield_serializer (PF_BITS=20): per-cycle compare against a line-position model
// plus directed lines with literal expected pixel patterns. Define TIA_PF_SCORE_EN to cover score mode.
module tb_tia_playfield_serializer;

    localparam int PF    = 20;
    localparam int LANES = 3;

    logic       clkp = 1'b0;
    logic       reset_bar = 1'b0;
    logic       line_start = 1'b0;
    logic       tick = 1'b0;
    logic       reflect = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_sel = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       pf;
    logic       busy;
`ifdef TIA_PF_SCORE_EN
    logic       pf_left;
    logic       pf_right;
    logic [39:0] cap_left;
    logic [39:0] cap_right;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    tia_playfield_serializer #(.PF_BITS(PF)) dut (
        .clkp       (clkp),
        .reset_bar  (reset_bar),
        .line_start (line_start),
        .tick       (tick),
        .reflect    (reflect),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
`ifdef TIA_PF_SCORE_EN
        .pf_left    (pf_left),
        .pf_right   (pf_right),
`endif
        .pf         (pf),
        .busy       (busy)
    );

    always #5 clkp = ~clkp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a line is 2*PF positions after line_start; position -> image bit by half and mirroring.
    logic [PF-1:0] m_img = '0;
    bit   m_active = 1'b0;
    int   m_pos = 0;
    bit   m_refl = 1'b0;
    bit   exp_pf = 1'b0;
    bit   exp_busy = 1'b0;
    bit   exp_left = 1'b0;
    bit   exp_right = 1'b0;

    function automatic int bit_at(input int p, input bit r);
        if (p < PF) return p;
        return r ? (2 * PF - 1 - p) : (p - PF);
    endfunction

    always @(posedge clkp or negedge reset_bar) begin
        if (!reset_bar) begin
            m_img     <= '0;
            m_active  <= 1'b0;
            m_pos     <= 0;
            m_refl    <= 1'b0;
            exp_pf    <= 1'b0;
            exp_busy  <= 1'b0;
            exp_left  <= 1'b0;
            exp_right <= 1'b0;
        end else begin
            exp_pf    <= m_active && m_img[bit_at(m_pos, m_refl)];
            exp_busy  <= m_active;
            exp_left  <= m_active && (m_pos < PF) && m_img[bit_at(m_pos, m_refl)];
            exp_right <= m_active && (m_pos >= PF) && m_img[bit_at(m_pos, m_refl)];
            if (line_start) begin
                m_active <= 1'b1;
                m_pos    <= 0;
            end else if (tick && m_active) begin
                if (m_pos == PF - 1) m_refl <= reflect;
                if (m_pos == 2 * PF - 1) m_active <= 1'b0;
                else m_pos <= m_pos + 1;
            end
            if (wr_en && int'(wr_sel) < LANES) begin
                for (int b = 0; b < 8; b++) begin
                    if (int'(wr_sel) * 8 + b < PF) m_img[int'(wr_sel) * 8 + b] <= wr_data[b];
                end
            end
        end
    end

    always @(negedge clkp) begin
        if (chk_en) begin
            check("pf_model", pf, exp_pf);
            check("busy_model", busy, exp_busy);
`ifdef TIA_PF_SCORE_EN
            check("left_model", pf_left, exp_left);
            check("right_model", pf_right, exp_right);
            check("pf_is_or", pf, pf_left | pf_right);
            check("not_both", pf_left & pf_right, 1'b0);
`endif
        end
    end

    task automatic wr(input int sel, input logic [7:0] d);
        wr_en = 1'b1;
        wr_sel = 2'(sel);
        wr_data = d;
        @(negedge clkp);
        wr_en = 1'b0;
        $display("write lane=%0d data=%02h", sel, d);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clkp);
            tick = 1'b0;
            @(negedge clkp);
        end
    endtask

    // One full line, a tick every 4 cycles; samples each position's pixel once it is stable.
    task automatic run_line(input logic refl_sw, input logic toggle_right, output logic [39:0] bits);
        line_start = 1'b1;
        @(negedge clkp);
        line_start = 1'b0;
        for (int p = 0; p < 40; p++) begin
            @(negedge clkp);
            @(negedge clkp);
            bits[p] = pf;
`ifdef TIA_PF_SCORE_EN
            cap_left[p]  = pf_left;
            cap_right[p] = pf_right;
`endif
            if (p == PF - 1) reflect = refl_sw;
            else if (p > PF - 1 && toggle_right) reflect = ~reflect;
            tick = 1'b1;
            @(negedge clkp);
            tick = 1'b0;
            if (p == 39) check("busy_hold", busy, 1'b1);
            @(negedge clkp);
        end
        check("busy_drop", busy, 1'b0);
        $display("line reflect=%0b toggle=%0b bits=%010h", refl_sw, toggle_right, bits);
    endtask

    logic [39:0] bits;

    initial begin
        // Reset held while the line controls toggle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clkp);
            line_start = ~line_start;
            tick = ~tick;
            check("rst_pf", pf, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        line_start = 1'b0;
        tick = 1'b0;
        @(negedge clkp);
        reset_bar = 1'b1;
        chk_en = 1'b1;
        @(negedge clkp);
        run_line(1'b0, 1'b0, bits);
        check("rst_image", bits, 40'h0);

        // Repeat and reflect with image 0x0000F.
        wr(0, 8'h0F);
        wr(1, 8'h00);
        wr(2, 8'h00);
        run_line(1'b0, 1'b0, bits);
        check("repeat", bits, 40'h00_00F0_000F);
        run_line(1'b1, 1'b1, bits);
        check("reflect", bits, 40'hF0_0000_000F);

        // Mid-line write at position 5.
        wr(0, 8'h00);
        line_start = 1'b1;
        @(negedge clkp);
        line_start = 1'b0;
        tick_n(5);
        @(negedge clkp);
        check("mid_pre", pf, 1'b0);
        wr_en = 1'b1;
        wr_sel = 2'd0;
        wr_data = 8'hFF;
        @(negedge clkp);
        wr_en = 1'b0;
        check("mid_w1", pf, 1'b0);
        @(negedge clkp);
        check("mid_w2", pf, 1'b1);
        $display("mid-line write pf=%0b", pf);

        // Reset mid-line: image and sequencer clear, ticks alone do not start a line.
        chk_en = 1'b0;
        #2 reset_bar = 1'b0;
        @(negedge clkp);
        check("mrst_pf", pf, 1'b0);
        check("mrst_busy", busy, 1'b0);
        reset_bar = 1'b1;
        @(negedge clkp);
        chk_en = 1'b1;
        tick_n(3);
        check("idle_after_rst_busy", busy, 1'b0);
        check("idle_after_rst_pf", pf, 1'b0);

        // Top lane truncation and out-of-range lane.
        wr(2, 8'hFF);
        wr(3, 8'hFF);
        run_line(1'b0, 1'b0, bits);
        check("lane2_trunc", bits, 40'hF0_000F_0000);

        // line_start colliding with a tick at position 12.
        wr(2, 8'h00);
        wr(0, 8'h01);
        line_start = 1'b1;
        @(negedge clkp);
        line_start = 1'b0;
        tick_n(12);
        line_start = 1'b1;
        tick = 1'b1;
        @(negedge clkp);
        line_start = 1'b0;
        tick = 1'b0;
        check("coll_s1", pf, 1'b0);
        @(negedge clkp);
        check("coll_restart", pf, 1'b1);
        $display("collision restart pf=%0b busy=%0b", pf, busy);
        tick_n(40);
        @(negedge clkp);
        check("coll_end_busy", busy, 1'b0);
        tick_n(3);
        check("idle_tick_pf", pf, 1'b0);
        check("idle_tick_busy", busy, 1'b0);

`ifdef TIA_PF_SCORE_EN
        wr(0, 8'hFF);
        wr(1, 8'hFF);
        wr(2, 8'hFF);
        run_line(1'b0, 1'b0, bits);
        check("score_pf", bits, 40'hFF_FFFF_FFFF);
        check("score_left", cap_left, 40'h00_000F_FFFF);
        check("score_right", cap_right, 40'hFF_FFF0_0000);
`endif

        @(negedge clkp);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
